fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, meaning the maximum number of consecutive words accepted from one owner before re-arbitration (legal 1..16).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  reset, asynchronous and active-low (reset=0 clears all state immediately).
REQ-004 SHALL have port en  input  1  block enable; also forwarded to the FIFO EN input.
REQ-005 SHALL have port req  input  4  per-requester write request; req[i] means lane i holds a valid word.
REQ-006 SHALL have port req_data  input  128  lane i word at bits [32i+31:32i].
REQ-007 SHALL have port FULL  input  1  FIFO full flag.
REQ-008 SHALL have port gnt  output  4  one-hot accept; gnt[i]=1 means lane i's word is written at this rising edge.
REQ-009 SHALL have port fifo_en  output  1  drives FIFO EN; equals en.
REQ-010 SHALL have port fifo_wr  output  1  drives FIFO WR.
REQ-011 SHALL have port fifo_data  output  32  drives FIFO data_in.
REQ-012 SHALL have port busy  output  1  registered; 1 while a lane owns the FIFO.
REQ-013 SHALL have port owner  output  2  registered index of current owner; 0 when idle.

Function
REQ-014 SHALL implement FSM states IDLE and BURST; plus registers last[1:0] (last owner), owner[1:0], cnt (burst count, width sufficient for MAX_BURST).
REQ-015 IDLE: gnt=0; at an edge with en=1 and req!=0, SHALL select owner by round-robin search order last+1, last+2, last+3, last (mod 4), load owner, cnt=0, go to BURST.
REQ-016 Arbitration SHALL take exactly one IDLE cycle; first accept is possible in the first BURST cycle.
REQ-017 BURST: gnt[owner] SHALL be combinational = req[owner] & ~FULL & en; all other gnt bits 0.
REQ-018 fifo_wr SHALL equal |gnt; fifo_data SHALL equal the owner lane word when fifo_wr=1, else 32'h0.
REQ-019 On each accept edge cnt SHALL increment; accept with cnt=MAX_BURST-1 SHALL go to IDLE and set last=owner.
REQ-020 BURST with req[owner]=0 (and en=1) SHALL go to IDLE at that edge, set last=owner, no write.
REQ-021 BURST with FULL=1 SHALL stall: no accept, cnt, owner and state held; resume without re-arbitration when FULL=0.
REQ-022 en=0 SHALL force gnt=0, fifo_wr=0 and freeze all state in any FSM state.
REQ-023 A word SHALL never be written to the FIFO while FULL=1; at most one write per cycle.
REQ-024 Requester SHALL hold req[i] and its word stable until gnt[i]; a lane not owning sees gnt[i]=0 regardless of req.
REQ-025 Single requester SHALL be re-granted after its burst ends (one IDLE bubble) if it is the only request.

Reset
REQ-026 reset=0 SHALL asynchronously set state=IDLE, owner=0, cnt=0, last=3, busy=0; hence gnt=0, fifo_wr=0, fifo_data=0 immediately, including mid-burst.
REQ-027 After reset release the first arbitration SHALL favour lane 0 (search starts at last+1=0).

Verification
REQ-028 Reset: reset=0 mid-burst (owner=2, cnt=1) -> gnt=0, fifo_wr=0, busy=0, owner=0 before next clock; release with req=4'b0001 -> one IDLE cycle then gnt=4'b0001.
REQ-029 Single lane: req=4'b0100, words 1..6 presented, FULL=0, MAX_BURST=4 -> FIFO writes 1,2,3,4 on consecutive edges, one idle cycle, then 5,6.
REQ-030 Contention: req=4'b1111 held, all lanes always valid -> owners 0,1,2,3,0 in order, each 4 writes, one idle cycle between bursts.
REQ-031 Backpressure: FULL=1 for 3 cycles after owner 1 writes 2 words -> gnt=0, fifo_wr=0 for 3 cycles, owner=1 held, then 2 more writes, then IDLE.
REQ-032 Early release: owner 1 drops req after 1 write, req=4'b1001 -> IDLE, next owner 3, then 0.
REQ-033 Enable: en=0 for 2 cycles mid-burst -> no writes, state frozen, fifo_en=0; burst completes with remaining count after en=1.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: four 32-bit requesters share one FIFO write port.
// A selected lane owns the port for up to MAX_BURST accepted words.
module fifo_wr_arbiter #(
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic [3:0]   req,
  input  logic [127:0] req_data,
  input  logic         FULL,
  output logic [3:0]   gnt,
  output logic         fifo_en,
  output logic         fifo_wr,
  output logic [31:0]  fifo_data,
  output logic         busy,
  output logic [1:0]   owner,
  output logic         dbg_state
);

  // Handshake: a lane presents req[i] with its word held stable; the word is
  // consumed at the rising edge where gnt[i]=1 (valid & ready in one cycle).

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int CNT_W = 5;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  state_t           state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       pick;
  logic             accept;

  // Search order last+1, last+2, last+3, last; the lowest offset wins.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] l);
    logic [1:0] c;
    logic [1:0] p;
    p = l;
    for (int k = 4; k >= 1; k--) begin
      c = l + 2'(k);
      if (r[c]) p = c;
    end
    return p;
  endfunction

  always_comb begin
    pick = rr_pick(req, last_q);
  end

  always_comb begin
    accept    = (state_q == BURST) && en && !FULL && req[owner_q];
    gnt       = accept ? (4'b0001 << owner_q) : 4'b0000;
    fifo_wr   = accept;
    fifo_data = accept ? req_data[{owner_q, 5'b00000} +: 32] : 32'h0;
    fifo_en   = en;
    busy      = (state_q == BURST);
    owner     = owner_q;
    dbg_state = state_q;
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    if (en) begin
      case (state_q)
        IDLE: begin
          if (req != 4'b0000) begin
            owner_d = pick;
            cnt_d   = '0;
            state_d = BURST;
          end
        end
        BURST: begin
          // FULL stalls the burst even if the owner has withdrawn its request.
          if (!FULL) begin
            if (req[owner_q]) begin
              if (cnt_q == CNT_LAST) begin
                state_d = IDLE;
                last_d  = owner_q;
                owner_d = 2'd0;
                cnt_d   = '0;
              end else begin
                cnt_d = cnt_q + 1'b1;
              end
            end else begin
              state_d = IDLE;
              last_d  = owner_q;
              owner_d = 2'd0;
              cnt_d   = '0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // last resets to 3 so the first search after reset starts at lane 0.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      last_q  <= 2'd3;
      owner_q <= 2'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: per-cycle expected outputs are queued by
// the driver and compared by a negedge monitor.
module tb_fifo_wr_arbiter;

  logic         clk;
  logic         reset;
  logic         en;
  logic [3:0]   req;
  logic [127:0] req_data;
  logic         FULL;
  logic [3:0]   gnt;
  logic         fifo_en;
  logic         fifo_wr;
  logic [31:0]  fifo_data;
  logic         busy;
  logic [1:0]   owner;
  logic         dbg_state;

  int checks = 0;
  int errors = 0;
  int cyc_id = 0;

  // Expected per cycle: {fifo_en, busy, owner, fifo_wr, gnt, fifo_data}
  logic [40:0] exp_q[$];
  int          tag_q[$];

  fifo_wr_arbiter #(.MAX_BURST(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .req       (req),
    .req_data  (req_data),
    .FULL      (FULL),
    .gnt       (gnt),
    .fifo_en   (fifo_en),
    .fifo_wr   (fifo_wr),
    .fifo_data (fifo_data),
    .busy      (busy),
    .owner     (owner),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // monitor / scoreboard
  always @(negedge clk) begin
    logic [40:0] e;
    logic [40:0] a;
    int          t;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {fifo_en, busy, owner, fifo_wr, gnt, fifo_data};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle%0d en/busy/own/wr/gnt/data got %h expected %h", t, a, e);
      end
    end
  end

  function automatic logic [127:0] ln(input int i, input logic [31:0] w);
    logic [127:0] v;
    v = 128'h0;
    v[32*i +: 32] = w;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp_v);
    end
  endtask

  // driver: apply inputs for one cycle and queue that cycle's expected outputs
  task automatic step(input logic e, input logic [3:0] r, input logic f,
                      input logic [127:0] d, input logic eb, input logic [1:0] eo,
                      input logic [3:0] eg, input logic [31:0] ed);
    @(posedge clk);
    #1;
    en = e; req = r; FULL = f; req_data = d;
    exp_q.push_back({e, eb, eo, (eg != 4'b0000), eg, ed});
    tag_q.push_back(cyc_id);
    cyc_id++;
  endtask

  // asserts reset away from the clock edge and checks outputs clear at once
  task automatic do_reset();
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_wr", 32'(fifo_wr), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_owner", 32'(owner), 32'h0);
    chk("rst_data", fifo_data, 32'h0);
    en = 1'b1; req = 4'b0000; FULL = 1'b0; req_data = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    logic [127:0] all;
    logic [127:0] d;
    reset = 1'b1; en = 1'b1; req = 4'b0000; FULL = 1'b0; req_data = '0;

    // single lane, two bursts with one idle bubble
    do_reset();
    step(1, 4'b0100, 0, ln(2, 1), 0, 0, 4'b0000, 0);
    for (int k = 1; k <= 4; k++)
      step(1, 4'b0100, 0, ln(2, k), 1, 2, 4'b0100, k);
    step(1, 4'b0100, 0, ln(2, 5), 0, 0, 4'b0000, 0);
    step(1, 4'b0100, 0, ln(2, 5), 1, 2, 4'b0100, 5);
    step(1, 4'b0100, 0, ln(2, 6), 1, 2, 4'b0100, 6);
    step(1, 4'b0000, 0, '0, 1, 2, 4'b0000, 0);
    step(1, 4'b0000, 0, '0, 0, 0, 4'b0000, 0);

    // full contention: owners 0,1,2,3,0
    do_reset();
    all = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
    step(1, 4'b1111, 0, all, 0, 0, 4'b0000, 0);
    for (int b = 0; b < 5; b++) begin
      for (int k = 0; k < 4; k++)
        step(1, 4'b1111, 0, all, 1, 2'(b % 4), 4'b0001 << (b % 4), 32'hA0 + 32'(b % 4));
      if (b < 4) step(1, 4'b1111, 0, all, 0, 0, 4'b0000, 0);
      else       step(1, 4'b0000, 0, all, 0, 0, 4'b0000, 0);
    end

    // backpressure on owner 1 after two writes
    step(1, 4'b0010, 0, ln(1, 32'h101), 0, 0, 4'b0000, 0);
    step(1, 4'b0010, 0, ln(1, 32'h101), 1, 1, 4'b0010, 32'h101);
    step(1, 4'b0010, 0, ln(1, 32'h102), 1, 1, 4'b0010, 32'h102);
    for (int k = 0; k < 3; k++)
      step(1, 4'b0010, 1, ln(1, 32'h103), 1, 1, 4'b0000, 0);
    step(1, 4'b0010, 0, ln(1, 32'h103), 1, 1, 4'b0010, 32'h103);
    step(1, 4'b0010, 0, ln(1, 32'h104), 1, 1, 4'b0010, 32'h104);
    step(1, 4'b0000, 0, '0, 0, 0, 4'b0000, 0);

    // early release by owner 1, then 3, then 0
    step(1, 4'b0010, 0, ln(1, 32'h201), 0, 0, 4'b0000, 0);
    step(1, 4'b0010, 0, ln(1, 32'h201), 1, 1, 4'b0010, 32'h201);
    d = {32'h303, 32'h0, 32'h0, 32'h300};
    step(1, 4'b1001, 0, d, 1, 1, 4'b0000, 0);
    step(1, 4'b1001, 0, d, 0, 0, 4'b0000, 0);
    for (int k = 0; k < 4; k++)
      step(1, 4'b1001, 0, d, 1, 3, 4'b1000, 32'h303);
    step(1, 4'b1001, 0, d, 0, 0, 4'b0000, 0);
    step(1, 4'b1001, 0, d, 1, 0, 4'b0001, 32'h300);
    step(1, 4'b0000, 0, '0, 1, 0, 4'b0000, 0);
    step(1, 4'b0000, 0, '0, 0, 0, 4'b0000, 0);

    // enable low mid-burst and in idle
    step(1, 4'b0100, 0, ln(2, 32'h401), 0, 0, 4'b0000, 0);
    step(1, 4'b0100, 0, ln(2, 32'h401), 1, 2, 4'b0100, 32'h401);
    step(1, 4'b0100, 0, ln(2, 32'h402), 1, 2, 4'b0100, 32'h402);
    step(0, 4'b0100, 0, ln(2, 32'h403), 1, 2, 4'b0000, 0);
    step(0, 4'b0100, 0, ln(2, 32'h403), 1, 2, 4'b0000, 0);
    step(1, 4'b0100, 0, ln(2, 32'h403), 1, 2, 4'b0100, 32'h403);
    step(1, 4'b0100, 0, ln(2, 32'h404), 1, 2, 4'b0100, 32'h404);
    step(1, 4'b0000, 0, '0, 0, 0, 4'b0000, 0);
    step(0, 4'b0001, 0, ln(0, 32'h501), 0, 0, 4'b0000, 0);
    step(0, 4'b0001, 0, ln(0, 32'h501), 0, 0, 4'b0000, 0);
    step(1, 4'b0001, 0, ln(0, 32'h501), 0, 0, 4'b0000, 0);
    step(1, 4'b0001, 0, ln(0, 32'h501), 1, 0, 4'b0001, 32'h501);
    step(1, 4'b0000, 0, '0, 1, 0, 4'b0000, 0);
    step(1, 4'b0000, 0, '0, 0, 0, 4'b0000, 0);

    // reset mid-burst (owner 2, one word written, stalled), then lane 0
    do_reset();
    step(1, 4'b0100, 0, ln(2, 32'h601), 0, 0, 4'b0000, 0);
    step(1, 4'b0100, 0, ln(2, 32'h601), 1, 2, 4'b0100, 32'h601);
    step(1, 4'b0100, 1, ln(2, 32'h602), 1, 2, 4'b0000, 0);
    do_reset();
    step(1, 4'b0001, 0, ln(0, 32'h701), 0, 0, 4'b0000, 0);
    step(1, 4'b0001, 0, ln(0, 32'h701), 1, 0, 4'b0001, 32'h701);
    step(1, 4'b0000, 0, '0, 1, 0, 4'b0000, 0);
    step(1, 4'b0000, 0, '0, 0, 0, 4'b0000, 0);

    // drain the scoreboard with a bounded wait
    for (int w = 0; w < 10 && exp_q.size() != 0; w++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
